// File: rtl/ins_mem_loader_if.sv
// Loader-side bus bundle: load command, word stream in, memory write port
// and fetch control out. The loader uses the slave modport and its driver
// uses the master modport.
interface ins_mem_loader_if #(
  parameter int LEN_W = 8
);
  logic             START;
  logic [31:0]      BASE_ADR;
  logic [LEN_W-1:0] LEN;
  logic             IN_VALID;
  logic [31:0]      IN_DATA;
  logic             IN_READY;
  logic             MEM_WRITE;
  logic [31:0]      MEM_ADR;
  logic [31:0]      MEM_DATA;
  logic             FETCH_STALL;
  logic             DONE;
  logic             ERR;

  modport master (
    output START, BASE_ADR, LEN, IN_VALID, IN_DATA,
    input  IN_READY, MEM_WRITE, MEM_ADR, MEM_DATA, FETCH_STALL, DONE, ERR
  );

  modport slave (
    input  START, BASE_ADR, LEN, IN_VALID, IN_DATA,
    output IN_READY, MEM_WRITE, MEM_ADR, MEM_DATA, FETCH_STALL, DONE, ERR
  );
endinterface

// File: rtl/ins_mem_loader.sv
// Instruction-memory loader: streams LEN words into memory starting at a
// word-aligned byte address, one write per accepted word, and stalls fetch
// from the cycle after START until the cycle of the DONE pulse.
module ins_mem_loader #(
  parameter int LEN_W = 8
) (
  input logic              CLK,
  input logic              RST_N,
  ins_mem_loader_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_FLUSH,
    ST_FIN
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      base_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] cnt_q;
  logic             mem_write_q;
  logic [31:0]      mem_adr_q;
  logic [31:0]      mem_data_q;
  logic             err_q;

  logic in_ready;
  logic fetch_stall;
  logic done;
  logic accept;
  logic misaligned;
  logic last_word;

  assign misaligned = (bus.BASE_ADR[1:0] != 2'b00);
  assign last_word  = (cnt_q == len_q - LEN_W'(1));

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values of its neighbours regardless of process ordering.
  always_ff @(posedge CLK) begin
    if (!RST_N) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state and state-decoded outputs.
  // NOTE: every signal written here gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    state_d     = state_q;
    in_ready    = 1'b0;
    fetch_stall = 1'b0;
    done        = 1'b0;
    accept      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.START && !misaligned) begin
          state_d = (bus.LEN == '0) ? ST_FIN : ST_LOAD;
        end
      end
      ST_LOAD: begin
        in_ready    = 1'b1;
        fetch_stall = 1'b1;
        accept      = bus.IN_VALID;
        if (accept && last_word) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        fetch_stall = 1'b1;
        state_d     = ST_FIN;
      end
      ST_FIN: begin
        fetch_stall = 1'b1;
        done        = 1'b1;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Command capture, word counter, registered memory write port, sticky ERR.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      base_q      <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      mem_write_q <= 1'b0;
      mem_adr_q   <= '0;
      mem_data_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      mem_write_q <= 1'b0;
      if (state_q == ST_IDLE && bus.START) begin
        if (misaligned) begin
          err_q <= 1'b1;
        end else if (bus.LEN != '0) begin
          base_q <= bus.BASE_ADR;
          len_q  <= bus.LEN;
          cnt_q  <= '0;
        end
      end
      if (accept) begin
        // Address wraps modulo 2^32 with no flag.
        mem_write_q <= 1'b1;
        mem_adr_q   <= base_q + (32'(cnt_q) << 2);
        mem_data_q  <= bus.IN_DATA;
        cnt_q       <= cnt_q + LEN_W'(1);
      end
    end
  end

  assign bus.IN_READY    = in_ready;
  assign bus.FETCH_STALL = fetch_stall;
  assign bus.DONE        = done;
  assign bus.MEM_WRITE   = mem_write_q;
  assign bus.MEM_ADR     = mem_adr_q;
  assign bus.MEM_DATA    = mem_data_q;
  assign bus.ERR         = err_q;

endmodule
